// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity encodings, the FSM state
// type used by both the transmit and receive directions, and the parity helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // data_xor is the XOR of all data bits; odd parity is its inverse.
  function automatic logic par_bit(input logic data_xor, input int par);
    return data_xor ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable DIV-cycle bit timer; emits a one-cycle tick at the end of each bit
// period while running, with an optional half-period preload for RX centring.
module uart_bit_timer #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  // First tick lands DIV/2-1 cycles after the load edge; the receiver loads one
  // cycle after its synchronised edge, so the sample sits DIV/2 after that edge.
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV - DIV / 2 + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= half ? HALF_LOAD : '0;
    end else if (run) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with ready/valid transmit handshake, 2-flop RX
// synchroniser, false-start rejection and framing/parity error reporting.
module uart_param
  import uart_pkg::*;
#(
  parameter int DIV       = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_done
);

  localparam int CW = $clog2(DIV);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  uart_state_e          tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [CW-1:0]        tx_cnt;
  logic                 tx_par;
  logic                 tx_tick;
  logic                 tx_accept;

  assign tx_accept = tx_valid && tx_ready;

  uart_bit_timer #(.DIV(DIV)) u_tx_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (tx_state != ST_IDLE),
    .load (tx_accept),
    .half (1'b0),
    .tick (tx_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        ST_IDLE: if (tx_accept) begin
          tx_shift <= tx_data;
          tx_par   <= par_bit(^tx_data, PARITY);
          txd      <= 1'b0;
          tx_ready <= 1'b0;
          tx_state <= ST_START;
        end
        ST_START: if (tx_tick) begin
          txd      <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_cnt   <= '0;
          tx_state <= ST_DATA;
        end
        ST_DATA: if (tx_tick) begin
          if (tx_cnt == DATA_LAST) begin
            tx_cnt <= '0;
            if (HAS_PAR) begin
              txd      <= tx_par;
              tx_state <= ST_PARITY;
            end else begin
              txd      <= 1'b1;
              tx_state <= ST_STOP;
            end
          end else begin
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_cnt   <= tx_cnt + 1'b1;
          end
        end
        ST_PARITY: if (tx_tick) begin
          txd      <= 1'b1;
          tx_state <= ST_STOP;
        end
        ST_STOP: if (tx_tick) begin
          if (tx_cnt == STOP_LAST) begin
            tx_state <= ST_IDLE;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  uart_state_e          rx_state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [DATA_BITS-1:0] rx_shift;
  logic [CW-1:0]        rx_cnt;
  logic                 rx_par_bad;
  logic                 rx_tick;
  logic                 rx_start;

  // Only a high-to-low step arms the receiver, which also covers waiting for the
  // line to recover after a framing error.
  assign rx_start = (rx_state == ST_IDLE) && rx_prev && !rx_s2;

  uart_bit_timer #(.DIV(DIV)) u_rx_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (rx_state != ST_IDLE),
    .load (rx_start),
    .half (1'b1),
    .tick (rx_tick)
  );

  // Synchroniser resets low so a line held low through reset release is never
  // mistaken for a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= ST_IDLE;
      rx_shift      <= '0;
      rx_cnt        <= '0;
      rx_par_bad    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        ST_IDLE: if (rx_start) rx_state <= ST_START;
        ST_START: if (rx_tick) begin
          if (rx_s2) begin
            rx_state <= ST_IDLE;
          end else begin
            rx_cnt     <= '0;
            rx_par_bad <= 1'b0;
            rx_state   <= ST_DATA;
          end
        end
        ST_DATA: if (rx_tick) begin
          rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_cnt == DATA_LAST) rx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
          else                     rx_cnt   <= rx_cnt + 1'b1;
        end
        ST_PARITY: if (rx_tick) begin
          rx_par_bad <= (rx_s2 != par_bit(^rx_shift, PARITY));
          rx_state   <= ST_STOP;
        end
        ST_STOP: if (rx_tick) begin
          rx_data       <= rx_shift;
          rx_frame_err  <= !rx_s2;
          rx_parity_err <= rx_par_bad;
          rx_valid      <= 1'b1;
          rx_state      <= ST_IDLE;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: two instances (8E1 and 5O2, DIV=16) checked
// against a frame-level reference model built from the serial framing rules.
module tb_uart_param;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       loop_a = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;

  logic       rxd_a, txd_a, tx_ready_a, tx_done_a, rx_valid_a, rx_fe_a, rx_pe_a;
  logic [7:0] rx_data_a;
  logic       rxd_b, txd_b, tx_ready_b, tx_done_b, rx_valid_b, rx_fe_b, rx_pe_b;
  logic [4:0] rx_data_b;

  logic       obs_txd, obs_tx_ready, obs_tx_done, obs_rx_valid, obs_fe, obs_pe;
  logic [7:0] obs_rx_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rxd_a = loop_a ? txd_a : rxd_drv;
  assign rxd_b = txd_b;

  uart_param #(.DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_frame_err(rx_fe_a), .rx_parity_err(rx_pe_a), .tx_data(tx_data),
    .tx_valid(tx_valid && !sel), .tx_ready(tx_ready_a), .txd(txd_a), .tx_done(tx_done_a)
  );

  uart_param #(.DIV(DIV), .DATA_BITS(5), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_frame_err(rx_fe_b), .rx_parity_err(rx_pe_b), .tx_data(tx_data[4:0]),
    .tx_valid(tx_valid && sel), .tx_ready(tx_ready_b), .txd(txd_b), .tx_done(tx_done_b)
  );

  assign obs_txd      = sel ? txd_b      : txd_a;
  assign obs_tx_ready = sel ? tx_ready_b : tx_ready_a;
  assign obs_tx_done  = sel ? tx_done_b  : tx_done_a;
  assign obs_rx_valid = sel ? rx_valid_b : rx_valid_a;
  assign obs_fe       = sel ? rx_fe_b    : rx_fe_a;
  assign obs_pe       = sel ? rx_pe_b    : rx_pe_a;
  assign obs_rx_data  = sel ? {3'b000, rx_data_b} : rx_data_a;

  function automatic int frame_len(input int db, input int par, input int stops);
    return 1 + db + ((par != 0) ? 1 : 0) + stops;
  endfunction

  // Line bits in transmission order, bit 0 first; unused upper bits stay 1.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int db,
                                             input int par);
    logic [15:0] f = '1;
    int n = 1;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par != 0) f[n] = ((ones % 2) == 1) ^ (par == 2);
    return f;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({txd_a, tx_ready_a, tx_done_a, rx_valid_a, rx_fe_a, rx_pe_a} !== 6'b110000)
      begin fails++; $display("[TB] FAIL reset_ctl_a: got %b expected 110000",
        {txd_a, tx_ready_a, tx_done_a, rx_valid_a, rx_fe_a, rx_pe_a}); end
    tests++;
    if ({txd_b, tx_ready_b, tx_done_b, rx_valid_b, rx_fe_b, rx_pe_b} !== 6'b110000)
      begin fails++; $display("[TB] FAIL reset_ctl_b: got %b expected 110000",
        {txd_b, tx_ready_b, tx_done_b, rx_valid_b, rx_fe_b, rx_pe_b}); end
    tests++;
    if (rx_data_a !== 8'h00 || rx_data_b !== 5'h00)
      begin fails++; $display("[TB] FAIL reset_rx_data: got %h/%h expected 00/00",
        rx_data_a, rx_data_b); end
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    tests++;
    if ({txd_a, tx_ready_a, rx_valid_a, txd_b, tx_ready_b, rx_valid_b} !== 6'b110110)
      begin fails++; $display("[TB] FAIL post_reset_idle: got %b expected 110110",
        {txd_a, tx_ready_a, rx_valid_a, txd_b, tx_ready_b, rx_valid_b}); end
  endtask

  // b selects the 5O2 instance; every frame loops back into its own receiver.
  task automatic test_tx_frame(input logic [7:0] d, input bit b);
    int db = b ? 5 : 8;
    int par = b ? 2 : 1;
    int stops = b ? 2 : 1;
    int len = frame_len(db, par, stops);
    logic [15:0] exp = frame_bits(d, db, par);
    logic [7:0] exp_rx = b ? (d & 8'h1F) : d;
    int done_at = -1;
    int ready_low = 0;
    int got_rx = 0;
    sel = b;
    loop_a = 1'b1;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tests++;
    if (obs_txd !== 1'b0)
      begin fails++; $display("[TB] FAIL tx_start_fall: got %b expected 0", obs_txd); end
    if (!obs_tx_ready) ready_low++;
    for (int c = 1; c <= (len + 1) * DIV; c++) begin
      @(negedge clk);
      if (c < len * DIV && (c % DIV) == DIV / 2) begin
        tests++;
        if (obs_txd !== exp[c / DIV])
          begin fails++; $display("[TB] FAIL tx_bit%0d (data %h): got %b expected %b",
            c / DIV, d, obs_txd, exp[c / DIV]); end
      end
      if (obs_rx_valid) begin
        got_rx++;
        tests++;
        if ({obs_rx_data, obs_fe, obs_pe} !== {exp_rx, 2'b00})
          begin fails++; $display("[TB] FAIL loop_rx: got data %h fe %b pe %b expected %h 0 0",
            obs_rx_data, obs_fe, obs_pe, exp_rx); end
      end
      if (obs_tx_done) begin
        done_at = c;
        break;
      end
      if (!obs_tx_ready) ready_low++;
    end
    tests++;
    if (done_at != len * DIV)
      begin fails++; $display("[TB] FAIL tx_done_time: got %0d expected %0d", done_at, len * DIV); end
    tests++;
    if (ready_low != len * DIV)
      begin fails++; $display("[TB] FAIL tx_ready_low: got %0d expected %0d", ready_low, len * DIV); end
    tests++;
    if (got_rx != 1)
      begin fails++; $display("[TB] FAIL loop_rx_count: got %0d expected 1", got_rx); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    int sent = 0;
    int rcv = 0;
    int last_done = -100;
    bit pend;
    words = '{8'h00, 8'hFF, 8'h3C, 8'($urandom)};
    sel = 1'b0;
    loop_a = 1'b1;
    @(negedge clk);
    tx_data = words[0];
    tx_valid = 1'b1;
    pend = obs_tx_ready;
    for (int c = 0; c < 6 * 11 * DIV && rcv < 4; c++) begin
      @(negedge clk);
      if (pend) begin
        tests++;
        if (obs_txd !== 1'b0)
          begin fails++; $display("[TB] FAIL b2b_start%0d: got %b expected 0", sent, obs_txd); end
        if (sent >= 1) begin
          tests++;
          if (c - last_done != 1)
            begin fails++; $display("[TB] FAIL b2b_gap%0d: got %0d expected 1", sent, c - last_done); end
        end
        sent++;
        if (sent < 4) tx_data = words[sent];
        else          tx_valid = 1'b0;
        pend = 1'b0;
      end
      if (tx_valid && obs_tx_ready) pend = 1'b1;
      if (obs_tx_done) last_done = c;
      if (obs_rx_valid && rcv < 4) begin
        tests++;
        if ({obs_rx_data, obs_fe, obs_pe} !== {words[rcv], 2'b00})
          begin fails++; $display("[TB] FAIL b2b_rx%0d: got data %h fe %b pe %b expected %h 0 0",
            rcv, obs_rx_data, obs_fe, obs_pe, words[rcv]); end
        rcv++;
      end
    end
    tx_valid = 1'b0;
    tests++;
    if (rcv != 4)
      begin fails++; $display("[TB] FAIL b2b_rx_count: got %0d expected 4", rcv); end
    repeat (2 * DIV) @(negedge clk);
  endtask

  // Drives one 8E1 frame into instance A and records when rx_valid appears,
  // counted in cycles from the start-bit edge.
  task automatic drive_rx(input logic [15:0] bits, input int len, output int valid_at,
                          output logic [7:0] data, output logic fe, output logic pe);
    valid_at = -1;
    data = '0;
    fe = 1'b0;
    pe = 1'b0;
    for (int k = 0; k < len + 2; k++) begin
      rxd_drv = (k < len) ? bits[k] : 1'b1;
      for (int j = 0; j < DIV; j++) begin
        @(negedge clk);
        if (rx_valid_a && valid_at < 0) begin
          valid_at = k * DIV + j + 1;
          data = rx_data_a;
          fe = rx_fe_a;
          pe = rx_pe_a;
        end
      end
    end
  endtask

  task automatic check_rx(input string name, input logic [15:0] bits, input logic [7:0] exp_d,
                          input logic exp_fe, input logic exp_pe);
    int at;
    logic [7:0] d;
    logic fe, pe;
    drive_rx(bits, 11, at, d, fe, pe);
    tests++;
    if (at <= 10 * DIV || at > 11 * DIV)
      begin fails++; $display("[TB] FAIL %s_valid_time: got %0d expected in (%0d,%0d]",
        name, at, 10 * DIV, 11 * DIV); end
    tests++;
    if ({d, fe, pe} !== {exp_d, exp_fe, exp_pe})
      begin fails++; $display("[TB] FAIL %s: got data %h fe %b pe %b expected %h %b %b",
        name, d, fe, pe, exp_d, exp_fe, exp_pe); end
  endtask

  task automatic test_false_start();
    int seen = 0;
    logic [7:0] w = 8'($urandom);
    sel = 1'b0;
    loop_a = 1'b0;
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (DIV) begin
      @(negedge clk);
      if (rx_valid_a) seen++;
    end
    tests++;
    if (seen != 0)
      begin fails++; $display("[TB] FAIL false_start_valid: got %0d pulses expected 0", seen); end
    check_rx("after_glitch", frame_bits(w, 8, 1), w, 1'b0, 1'b0);
  endtask

  task automatic test_errors();
    logic [7:0] w = 8'($urandom);
    logic [15:0] f;
    sel = 1'b0;
    loop_a = 1'b0;
    f = frame_bits(w, 8, 1);
    f[10] = 1'b0;
    check_rx("frame_err", f, w, 1'b1, 1'b0);
    f = frame_bits(8'h5A, 8, 1);
    f[9] = ~f[9];
    check_rx("parity_err", f, 8'h5A, 1'b0, 1'b1);
    w = 8'($urandom);
    check_rx("clean_rx", frame_bits(w, 8, 1), w, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w = 8'($urandom) & 8'hF7;
    int done_cnt = 0;
    int valid_cnt = 0;
    int high_miss = 0;
    sel = 1'b0;
    loop_a = 1'b1;
    @(negedge clk);
    tx_data = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4 * DIV + 5) @(negedge clk);
    tests++;
    if (txd_a !== 1'b0)
      begin fails++; $display("[TB] FAIL mid_frame_bit3: got %b expected 0", txd_a); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({txd_a, tx_ready_a} !== 2'b11)
      begin fails++; $display("[TB] FAIL async_reset_tx: got %b expected 11", {txd_a, tx_ready_a}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (16 * DIV) begin
      @(negedge clk);
      if (tx_done_a) done_cnt++;
      if (rx_valid_a) valid_cnt++;
      if (txd_a !== 1'b1) high_miss++;
    end
    tests++;
    if (done_cnt != 0 || valid_cnt != 0)
      begin fails++; $display("[TB] FAIL reset_no_pulses: got done %0d valid %0d expected 0 0",
        done_cnt, valid_cnt); end
    tests++;
    if (high_miss != 0)
      begin fails++; $display("[TB] FAIL reset_txd_idle: got %0d low cycles expected 0", high_miss); end
  endtask

  task automatic test_sweep();
    test_tx_frame(8'h15, 1'b1);
    test_tx_frame(8'($urandom), 1'b1);
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'hA5, 1'b0);
    test_tx_frame(8'($urandom), 1'b0);
    test_back_to_back();
    test_false_start();
    test_errors();
    test_reset_mid_frame();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
